rf_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single write port of the 32-entry CPU register file between two requesters: the ALU result path (source A) and the load/memory path (source B). Round-robin arbitration uses valid/ready handshakes. Each accepted request is registered and presented to the register file write port one cycle later. Writes to x0 are suppressed, and a saturating counter records arbitration conflicts for performance debug.

---
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 tb/tb_rf_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: ALU (A) and load unit (B) share one register file write port.
// Ready is combinational. The accepted write reaches rf_* one cycle later. At most one grant per cycle; losers stall.
module rf_wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             pri_b,
    output logic [15:0]      conf_cnt
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    pri_e             state_q, state_d;
    logic             gnt_a, gnt_b, conflict;
    logic             we_q, we_d;
    logic [4:0]       wa_q, wa_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [15:0]      cnt_q, cnt_d;

    // Grant and priority next-state; the loser under contention becomes favoured.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        state_d = state_q;
        if (rstn && en) begin
            if (a_valid && (!b_valid || state_q == PRI_A)) begin
                gnt_a = 1'b1;
            end else if (b_valid) begin
                gnt_b = 1'b1;
            end
        end
        if (gnt_a) begin
            state_d = PRI_B;
        end else if (gnt_b) begin
            state_d = PRI_A;
        end
    end

    always_comb begin
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        conflict = en && a_valid && b_valid;
        cnt_d    = cnt_q;
        if (gnt_a) begin
            we_d = (a_addr != 5'd0);
            wa_d = a_addr;
            wd_d = a_data;
        end else if (gnt_b) begin
            we_d = (b_addr != 5'd0);
            wa_d = b_addr;
            wd_d = b_data;
        end
        if (conflict && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= PRI_A;
            we_q    <= 1'b0;
            wa_q    <= 5'd0;
            wd_q    <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_ready  = gnt_a;
    assign b_ready  = gnt_b;
    assign rf_we    = we_q;
    assign rf_wa    = wa_q;
    assign rf_wd    = wd_q;
    assign pri_b    = (state_q == PRI_B);
    assign conf_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations plus random traffic against a behavioural model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, rf_we, pri_b;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [15:0] conf_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    bit a_hs, b_hs;

    rf_wb_arbiter #(.WIDTH(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .pri_b    (pri_b),
        .conf_cnt (conf_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who wins, what lands on the port, how many conflicts seen.
    bit          m_pri = 1'b0;
    bit          m_we  = 1'b0;
    logic [4:0]  m_wa  = 5'd0;
    logic [31:0] m_wd  = 32'd0;
    int          m_cnt = 0;
    logic [1:0]  g_m, g_c;

    // Returns {grant_b, grant_a}.
    function automatic logic [1:0] model_grant(input logic r, input logic e, input logic av,
                                               input logic bv, input bit p);
        if (!r || !e) return 2'b00;
        if (av && bv) return p ? 2'b10 : 2'b01;
        return {bv, av};
    endfunction

    always @(posedge clk) begin
        g_m = model_grant(rstn, en, a_valid, b_valid, m_pri);
        if (!rstn) begin
            m_pri = 1'b0;
            m_we  = 1'b0;
            m_wa  = 5'd0;
            m_wd  = 32'd0;
            m_cnt = 0;
        end else begin
            m_we = 1'b0;
            if (g_m != 2'b00) begin
                m_wa  = g_m[0] ? a_addr : b_addr;
                m_wd  = g_m[0] ? a_data : b_data;
                m_we  = (m_wa != 5'd0);
                m_pri = g_m[0];
            end
            if (en && a_valid && b_valid && m_cnt < 65535) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            g_c = model_grant(rstn, en, a_valid, b_valid, m_pri);
            chk("a_ready",  32'(a_ready),  32'(g_c[0]));
            chk("b_ready",  32'(b_ready),  32'(g_c[1]));
            chk("rf_we",    32'(rf_we),    32'(m_we));
            chk("rf_wa",    32'(rf_wa),    32'(m_wa));
            chk("rf_wd",    rf_wd,         m_wd);
            chk("pri_b",    32'(pri_b),    32'(m_pri));
            chk("conf_cnt", 32'(conf_cnt), 32'(m_cnt));
        end
    end

    task automatic post;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = 5'd0; b_addr = 5'd0; a_data = 32'd0; b_data = 32'd0;
        post;
        post;
        neg;
        chk("rst_we",  32'(rf_we),    32'd0);
        chk("rst_wa",  32'(rf_wa),    32'd0);
        chk("rst_wd",  rf_wd,         32'd0);
        chk("rst_pri", 32'(pri_b),    32'd0);
        chk("rst_cnt", 32'(conf_cnt), 32'd0);
        chk_on = 1'b1;

        // A alone
        post;
        rstn = 1'b1; en = 1'b1; a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        neg;
        chk("t1_a_ready", 32'(a_ready), 32'd1);
        post;
        a_valid = 1'b0;
        neg;
        chk("t1_we",  32'(rf_we), 32'd1);
        chk("t1_wa",  32'(rf_wa), 32'd5);
        chk("t1_wd",  rf_wd,      32'h1234);
        chk("t1_pri", 32'(pri_b), 32'd1);

        // Contention from reset
        post;
        rstn = 1'b0;
        post;
        rstn = 1'b1;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            post;
            if (i == 3) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            neg;
            chk("t2_wa", 32'(rf_wa), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_we", 32'(rf_we), 32'd1);
        end
        chk("t2_cnt", 32'(conf_cnt), 32'd4);
        chk("t2_pri", 32'(pri_b),    32'd0);

        // Write to x0 is accepted but suppressed
        post;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        neg;
        chk("t3_a_ready", 32'(a_ready), 32'd1);
        post;
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        neg;
        chk("t3_pri_pre", 32'(pri_b),   32'd1);
        chk("t3_b_ready", 32'(b_ready), 32'd1);
        post;
        b_valid = 1'b0;
        neg;
        chk("t3_we",  32'(rf_we), 32'd0);
        chk("t3_pri", 32'(pri_b), 32'd0);
        chk("t3_wa",  32'(rf_wa), 32'd0);
        chk("t3_wd",  rf_wd,      32'hFFFF_FFFF);

        // Enable low stalls everything
        post;
        en = 1'b0;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            neg;
            chk("t4_a_ready", 32'(a_ready),  32'd0);
            chk("t4_b_ready", 32'(b_ready),  32'd0);
            chk("t4_we",      32'(rf_we),    32'd0);
            chk("t4_cnt",     32'(conf_cnt), 32'd4);
            chk("t4_pri",     32'(pri_b),    32'd0);
            post;
        end
        en = 1'b1;
        neg;
        chk("t4_first_a", 32'(a_ready), 32'd1);
        chk("t4_first_b", 32'(b_ready), 32'd0);
        post;
        a_valid = 1'b0;
        neg;
        chk("t4_wa_a",  32'(rf_wa),    32'd4);
        chk("t4_b_rdy", 32'(b_ready),  32'd1);
        chk("t4_cnt5",  32'(conf_cnt), 32'd5);
        post;
        b_valid = 1'b0;
        neg;
        chk("t4_wa_b", 32'(rf_wa), 32'd6);

        // Saturation of the conflict counter
        post;
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
        for (int i = 0; i < 65540; i++) post;
        neg;
        chk("t5_sat", 32'(conf_cnt), 32'h0000_FFFF);
        post;
        a_valid = 1'b0;
        b_valid = 1'b0;
        neg;
        chk("t5_hold", 32'(conf_cnt), 32'h0000_FFFF);

        // Reset right after an A transfer, with A still requesting
        post;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        post;
        a_addr = 5'd9; a_data = 32'h99; rstn = 1'b0;
        neg;
        chk("t6_rdy_rst", 32'(a_ready), 32'd0);
        chk("t6_we_pre",  32'(rf_we),   32'd1);
        chk("t6_wa_pre",  32'(rf_wa),   32'd7);
        post;
        rstn = 1'b1; a_valid = 1'b0;
        neg;
        chk("t6_we",  32'(rf_we),    32'd0);
        chk("t6_wa",  32'(rf_wa),    32'd0);
        chk("t6_wd",  rf_wd,         32'd0);
        chk("t6_pri", 32'(pri_b),    32'd0);
        chk("t6_cnt", 32'(conf_cnt), 32'd0);

        // Random traffic; requesters hold their request until it is taken
        for (int i = 0; i < 3000; i++) begin
            neg;
            a_hs = a_valid && a_ready;
            b_hs = b_valid && b_ready;
            post;
            rstn = ($urandom_range(99) != 0);
            en   = ($urandom_range(9) != 0);
            if (!a_valid || a_hs) begin
                a_valid = ($urandom_range(2) != 0);
                a_addr  = 5'($urandom_range(31));
                a_data  = $urandom;
            end
            if (!b_valid || b_hs) begin
                b_valid = ($urandom_range(2) != 0);
                b_addr  = 5'($urandom_range(31));
                b_data  = $urandom;
            end
        end
        post;
        neg;
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
